// File: rtl/shift_register_pkg.sv
// Shared types and sizing helpers for the serial frame transmitter.
package shift_register_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } tx_state_t;

  // Bits on the wire per frame, not counting the idle gap.
  function automatic int frame_bits(input int width, input int parity_en);
    return 1 + width + ((parity_en != 0) ? 1 : 0);
  endfunction

  // One counter serves both the data bits (WIDTH-1..0) and the gap (GAP-1..0).
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap + 1) ? width : gap + 1;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/shift_register_tx_hold.sv
// One-entry holding register between the valid/ready source and the frame FSM.
module shift_register_tx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             drain_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  // Accept needs an empty register and drain needs a full one, so they never coincide.
  assign accept = tx_valid & ~full_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = tx_data;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign tx_ready = ~full_q;
  assign full_o   = full_q;
  assign data_o   = data_q;

endmodule

// File: rtl/shift_register_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits MSB-first,
// optional parity bit, then GAP idle zeros.
module shift_register_tx
  import shift_register_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0,
  parameter int GAP        = 2
) (
  input  logic             C,
  input  logic             RN,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             SO,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = cnt_width(WIDTH, GAP);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic            ODD_BIT  = (ODD_PARITY != 0);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             drain;
  logic             frame_end;
  logic             after_gap;
  logic             load_next;

  shift_register_tx_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .C        (C),
    .RN       (RN),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .drain_i  (drain),
    .full_o   (hold_full),
    .data_o   (hold_data)
  );

  // SO and done are the values belonging to the state being entered, so they
  // are computed alongside state_d and registered together with it.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    parity_d  = parity_q;
    so_d      = 1'b0;
    done_d    = 1'b0;
    drain     = 1'b0;
    frame_end = 1'b0;
    after_gap = 1'b0;
    load_next = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full) begin
          load_next = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = BIT_LAST;
        so_d    = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_ONE;
          so_d    = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
          done_d  = (PARITY_EN == 0) && (cnt_q == CNT_ONE);
        end else if (PARITY_EN != 0) begin
          state_d = ST_PARITY;
          so_d    = parity_q;
          done_d  = 1'b1;
        end else begin
          frame_end = 1'b1;
        end
      end
      ST_PARITY: begin
        frame_end = 1'b1;
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          after_gap = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_end) begin
      if (GAP > 0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LAST;
      end else begin
        after_gap = 1'b1;
      end
    end

    if (after_gap) begin
      if (hold_full) begin
        load_next = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Parity is latched from the word entering the shifter, never from live tx_data.
    if (load_next) begin
      state_d  = ST_START;
      shreg_d  = hold_data;
      parity_d = (^hold_data) ^ ODD_BIT;
      so_d     = 1'b1;
      drain    = 1'b1;
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      so_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      so_q     <= so_d;
      done_q   <= done_d;
    end
  end

  assign SO   = so_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
